// File: rtl/display_driver.sv
// display_driver
//
// Drives a 4-digit, common-anode 7-segment display with a stopwatch time
// given in deciseconds. The format is SSS.d: the decimal point sits after
// digit 1.
//
// The binary value is converted to BCD by a free-running double-dabble FSM.
// The FSM states are IDLE, SHIFT x14 and LOAD, so one conversion takes 16
// clocks. Only a finished conversion is copied into the displayed BCD register.
//
// A prescaler steps a 2-bit digit index every SCAN_DIV clocks. The digit
// enables, segments and decimal point are registered from that index.
//
// Parameters
//   SCAN_DIV  clocks each digit stays enabled (>= 1)
//   BLANK_LZ  1: blank leading zeros on digits 3 and 2
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   number     elapsed time in deciseconds (values above 9999 show 9999)
//   an         active-low digit enables, bit 3 = leftmost digit
//   seg        active-low segments {g,f,e,d,c,b,a}
//   dp         active-low decimal point
//   bcd_valid  one-cycle pulse when the displayed BCD register updates

module display_driver #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] number,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        bcd_valid
);

  localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(SCAN_DIV - 1);
  localparam logic [13:0] MaxVal = 14'd9999;
  localparam logic [3:0] LastIter = 4'd13;
  localparam logic [6:0] SegBlank = 7'h7F;

  // ---------------------------------------------------------------------------
  // Binary-to-BCD conversion FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLoad
  } state_e;

  state_e      state_q;
  logic [13:0] bin_q;       // binary value being shifted out
  logic [15:0] scratch_q;   // BCD being built up
  logic [3:0]  iter_q;      // completed SHIFT iterations
  logic [15:0] bcd_q;       // BCD value currently on the display
  logic [15:0] scratch_adj; // scratch after the add-3 correction

  // Add 3 to every nibble >= 5 so that the next shift carries into the next decade.
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[i*4 +: 4] >= 4'd5) begin
        scratch_adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      bcd_q     <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          // The input is sampled only here. Later changes wait for the next conversion.
          bin_q     <= (number > MaxVal) ? MaxVal : number;
          scratch_q <= '0;
          iter_q    <= '0;
          state_q   <= StShift;
        end
        StShift: begin
          {scratch_q, bin_q} <= {scratch_adj, bin_q} << 1;
          iter_q             <= iter_q + 4'd1;
          if (iter_q == LastIter) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          bcd_q     <= scratch_q;
          bcd_valid <= 1'b1;
          state_q   <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Scan prescaler and digit index
  // ---------------------------------------------------------------------------
  logic [PreW-1:0] pre_q;
  logic [1:0]      idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_q == PreMax) begin
      pre_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit select, blanking and segment decode
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b100_0000;
      4'd1:    s = 7'b111_1001;
      4'd2:    s = 7'b010_0100;
      4'd3:    s = 7'b011_0000;
      4'd4:    s = 7'b001_1001;
      4'd5:    s = 7'b001_0010;
      4'd6:    s = 7'b000_0010;
      4'd7:    s = 7'b111_1000;
      4'd8:    s = 7'b000_0000;
      4'd9:    s = 7'b001_0000;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  logic [3:0] digit;
  logic       blank;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    case (idx_q)
      2'd0: digit = bcd_q[3:0];
      2'd1: digit = bcd_q[7:4];
      2'd2: digit = bcd_q[11:8];
      2'd3: digit = bcd_q[15:12];
      default: digit = 4'd0;
    endcase
    // Digits 1 and 0 always show, so zero reads "0.0".
    if (BLANK_LZ) begin
      if (idx_q == 2'd3 && bcd_q[15:12] == 4'd0) begin
        blank = 1'b1;
      end
      if (idx_q == 2'd2 && bcd_q[15:8] == 8'd0) begin
        blank = 1'b1;
      end
    end
    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank ? SegBlank : seg_decode(digit);
    dp_d  = (idx_q != 2'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= SegBlank;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_display_driver.sv
// tb_display_driver
//
// Randomised and directed stimulus for display_driver with SCAN_DIV=4.
// At each conversion start, the stimulus side pushes the expected BCD value
// onto a queue. That value is worked out from decimal arithmetic. A monitor
// on the falling edge does two things:
//   - compares the scan outputs against the scan schedule and the value last
//     shown;
//   - pops the queue whenever bcd_valid pulses.

module tb_display_driver;

  localparam int unsigned ScanDiv = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] number = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        bcd_valid;

  int errors = 0;
  int checks = 0;
  int k = 0;                // rising edges since reset release
  logic [15:0] exp_q[$];    // expected BCD results, one per conversion started
  logic [15:0] shown = '0;  // value the display should currently show

  display_driver #(
    .SCAN_DIV(ScanDiv),
    .BLANK_LZ(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .number(number),
    .an(an),
    .seg(seg),
    .dp(dp),
    .bcd_valid(bcd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input logic [13:0] n);
    int v;
    v = (int'(n) > 9999) ? 9999 : int'(n);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] b, input int idx);
    int thou;
    int hund;
    int nib;
    thou = int'(b[15:12]);
    hund = int'(b[11:8]);
    if (idx == 3 && thou == 0) return 7'h7F;
    if (idx == 2 && thou == 0 && hund == 0) return 7'h7F;
    nib = int'((b >> (idx * 4)) & 16'h000F);
    return seg_of(nib);
  endfunction

  // A conversion samples number on edges 1, 17, 33, ... after reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0;
      exp_q.delete();
    end else begin
      k <= k + 1;
      if ((k + 1) % 16 == 1) exp_q.push_back(to_bcd(number));
    end
  end

  // Monitor: the outputs after edge k reflect the digit index and BCD value
  // as they stood after edge k-1.
  initial begin
    int d;
    logic [3:0]  ea;
    logic [6:0]  es;
    logic        edp;
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        shown = '0;
      end else if (k >= 1) begin
        d   = ((k - 1) / int'(ScanDiv)) % 4;
        ea  = ~(4'b0001 << d);
        es  = exp_seg(shown, d);
        edp = (d == 1) ? 1'b0 : 1'b1;
        check("an", 32'(an), 32'(ea));
        check("seg", 32'(seg), 32'(es));
        check("dp", 32'(dp), 32'(edp));
        check("bcd_valid_timing", 32'(bcd_valid), 32'((k % 16) == 0));
        if (bcd_valid) begin
          if (exp_q.size() == 0) begin
            check("bcd_valid_unexpected", 32'(bcd_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("bcd_reg", 32'(dut.bcd_q), 32'(e));
            shown = e;
          end
        end
      end
    end
  end

  task automatic wait_phase(input int p);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (k % 16 == p) return;
    end
    check("wait_phase_timeout", 32'(k % 16), 32'(p));
  endtask

  initial begin
    number = 14'd1234;
    #10;
    check("reset_an", 32'(an), 32'hF);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_dp", 32'(dp), 32'h1);
    check("reset_bcd_valid", 32'(bcd_valid), 32'h0);
    #13 rst_n = 1'b1;

    // Conversion latency and period with a steady input.
    repeat (48) @(posedge clk);
    #1 number = 14'd567;
    repeat (40) @(posedge clk);
    // Clamp above 9999.
    #1 number = 14'd10000;
    repeat (40) @(posedge clk);
    // Zero with leading-zero blanking.
    #1 number = 14'd0;
    repeat (40) @(posedge clk);

    // Input change partway through SHIFT must not disturb the conversion in progress.
    #1 number = 14'd100;
    wait_phase(1);
    wait_phase(6);
    number = 14'd200;
    repeat (40) @(posedge clk);

    for (int i = 0; i < 20; i++) begin
      #1 number = 14'($urandom_range(0, 16383));
      repeat ($urandom_range(1, 40)) @(posedge clk);
    end

    // Reset pulsed during SHIFT.
    #1 number = 14'd4321;
    wait_phase(7);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_an", 32'(an), 32'hF);
    check("midreset_seg", 32'(seg), 32'h7F);
    check("midreset_dp", 32'(dp), 32'h1);
    check("midreset_bcd_valid", 32'(bcd_valid), 32'h0);
    check("midreset_bcd_reg", 32'(dut.bcd_q), 32'h0);
    #12 rst_n = 1'b1;
    repeat (40) @(posedge clk);

    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_driver.md
DISPLAY_DRIVER -- requirements
Module: display_driver

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles each digit stays enabled (1 ms at 50 MHz).
REQ-002 The block SHALL have parameter BLANK_LZ, default 1, meaning leading-zero blanking on digits 3 and 2 when 1.
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port number, input, 14 bits, the unsigned elapsed time in deciseconds from the stopwatch counter.
REQ-006 The block SHALL have port an, output, 4 bits, the active-low digit enables, with bit 3 as the leftmost digit.
REQ-007 The block SHALL have port seg, output, 7 bits, the active-low segments ordered {g,f,e,d,c,b,a}.
REQ-008 The block SHALL have port dp, output, 1 bit, the active-low decimal point.
REQ-009 The block SHALL have port bcd_valid, output, 1 bit, a one-cycle pulse when the displayed BCD register updates.

Function
REQ-010 The conversion FSM SHALL have the states IDLE, SHIFT and LOAD, and SHALL be free-running with no external start signal.
REQ-011 In IDLE, the FSM SHALL capture number into a 14-bit shift register, clamping values above 9999 to 9999, clear a 16-bit BCD scratch register, clear the iteration count, and go to SHIFT.
REQ-012 In SHIFT, on each cycle the FSM SHALL add 3 to every scratch nibble >= 5, then shift {scratch, binary} left by one bit.
REQ-013 The FSM SHALL perform exactly 14 SHIFT iterations and then go to LOAD.
REQ-014 In LOAD, the FSM SHALL copy the scratch register to the display BCD register, pulse bcd_valid for one cycle, and return to IDLE.
REQ-015 A conversion cycle SHALL be 16 clocks (1 IDLE + 14 SHIFT + 1 LOAD), so the display reflects number sampled at most 32 clocks earlier.
REQ-016 Changes on number during SHIFT or LOAD SHALL NOT affect the conversion in progress.
REQ-017 The display BCD register SHALL change only in LOAD, so no partial conversion is ever displayed.
REQ-018 A scan prescaler SHALL count from 0 to SCAN_DIV-1 and wrap; on each wrap a 2-bit digit index SHALL advance 0,1,2,3,0 and so on.
REQ-019 an SHALL drive low only the bit selected by the digit index; exactly one bit of an SHALL be low at any time out of reset.
REQ-020 seg SHALL be the standard 7-segment decode of the selected BCD nibble; nibble codes 10 to 15 SHALL blank (seg=7'h7F).
REQ-021 dp SHALL be 0 only while digit index 1 is selected, giving the format SSS.d.
REQ-022 When BLANK_LZ=1, digit 3 SHALL blank if its nibble is 0.
REQ-023 When BLANK_LZ=1, digit 2 SHALL blank if digits 3 and 2 are both 0.
REQ-024 Digits 1 and 0 SHALL never blank, so a value of 0 displays "0.0".
REQ-025 The an, seg and dp outputs SHALL be registered, so they change one clock after the digit index changes.

Reset
REQ-026 While rst_n=0, the block SHALL immediately force an=4'b1111, seg=7'h7F, dp=1, bcd_valid=0, the FSM to IDLE, the display BCD register to 0, the prescaler to 0 and the digit index to 0.
REQ-027 Reset asserted mid-SHIFT SHALL abandon the conversion and SHALL NOT update the display BCD register.
REQ-028 After rst_n rises, the first bcd_valid pulse SHALL occur on the 16th rising clock edge.

Verification
REQ-029 The bench SHALL cover conversion latency: number=1234 held from reset -> bcd_valid pulses every 16 cycles and the BCD register reads 16'h1234.
REQ-030 The bench SHALL cover the scan sequence: with SCAN_DIV=4 and number=567 -> an steps 1110, 1101, 1011, 0111; seg shows 7, 6, 5 and then blank; dp is low only while an=1101.
REQ-031 The bench SHALL cover clamping: number=10000 -> the display BCD register reads 16'h9999.
REQ-032 The bench SHALL cover zero: number=0 -> digits 3 and 2 are blank (seg=7'h7F), digit 1 shows "0" with dp low, and digit 0 shows "0".
REQ-033 The bench SHALL cover input changes mid-conversion: number changes from 100 to 200 at cycle 5 of SHIFT -> the next LOAD gives 16'h0100 and the following LOAD gives 16'h0200.
REQ-034 The bench SHALL cover reset mid-operation: rst_n is pulsed low during SHIFT -> outputs go to reset values asynchronously, and no bcd_valid occurs until 16 cycles after release.
